// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads the combinational ROM,
// buffers {pc, word} pairs in a small FIFO and presents them to decode.
module instr_fetch_unit #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC   = 32'h0040_0000,
  parameter int unsigned                IMEM_WORDS = 1024,
  parameter int unsigned                FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rd,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  dec_ready,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] LAST_PC  = RESET_PC + DATA_WIDTH'(4 * (IMEM_WORDS - 1));
  localparam logic [CW-1:0]         FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_fault_pc;
  logic [DATA_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_word [FIFO_DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;

  state_t                w_state_nx;
  logic [DATA_WIDTH-1:0] w_fetch_pc_nx;
  logic [DATA_WIDTH-1:0] w_fault_pc_nx;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_head_valid;

  function automatic logic in_window(input logic [DATA_WIDTH-1:0] pc);
    return (pc >= RESET_PC) && (pc <= LAST_PC);
  endfunction

  function automatic logic target_ok(input logic [DATA_WIDTH-1:0] pc);
    return (pc[1:0] == 2'b00) && in_window(pc);
  endfunction

  assign w_head_valid = (r_count != {CW{1'b0}});
  assign imem_addr    = r_fetch_pc;
  assign inst_valid   = w_head_valid;
  assign inst         = r_mem_word[r_rd_ptr];
  assign inst_pc      = r_mem_pc[r_rd_ptr];
  assign fault        = (r_state == S_HALT);
  assign fault_pc     = r_fault_pc;

  // Next-state decision: redirect beats pop/push; an out-of-window fetch PC
  // only faults once it would actually be pushed.
  always_comb begin
    w_state_nx    = r_state;
    w_fetch_pc_nx = r_fetch_pc;
    w_fault_pc_nx = r_fault_pc;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (target_ok(redirect_target)) begin
            w_fetch_pc_nx = redirect_target;
          end else begin
            w_state_nx    = S_HALT;
            w_fault_pc_nx = redirect_target;
          end
        end else begin
          w_pop = w_head_valid & dec_ready;
          if ((r_count < FULL_CNT) || w_pop) begin
            if (in_window(r_fetch_pc)) begin
              w_push        = 1'b1;
              w_fetch_pc_nx = r_fetch_pc + DATA_WIDTH'(4);
            end else begin
              w_state_nx    = S_HALT;
              w_fault_pc_nx = r_fetch_pc;
            end
          end else begin
            w_push = 1'b0;
          end
        end
      end
      S_HALT: begin
        w_pop = w_head_valid & dec_ready;
      end
      default: begin
        w_state_nx = S_HALT;
      end
    endcase
  end

  // State, fetch PC and FIFO storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_PC;
      r_fault_pc <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_word[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_fetch_pc_nx;
      r_fault_pc <= w_fault_pc_nx;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
          r_mem_word[r_wr_ptr] <= imem_rd;
          r_wr_ptr             <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end requester for the instruction memory. It owns the program counter and drives word addresses into the combinational-read instruction ROM. It captures each returned word together with its PC into a small prefetch FIFO and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects and flags illegal fetch addresses.

## Interface
- `DATA_WIDTH`, 32, width of instructions, PCs and addresses.
- `RESET_PC`, 32'h0040_0000, first fetch address after reset; base of the instruction window.
- `IMEM_WORDS`, 1024, number of words in the instruction window; legal PCs are RESET_PC .. RESET_PC+4*IMEM_WORDS-4.
- `FIFO_DEPTH`, 2, prefetch entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  DATA_WIDTH  byte address to instruction memory; equals current fetch PC.
- `imem_rd`  in  DATA_WIDTH  instruction word; combinational function of `imem_addr` within the same cycle.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_target`  in  DATA_WIDTH  new fetch PC, sampled when `redirect_valid`=1.
- `inst_valid`  out  1  FIFO head holds an instruction.
- `inst`  out  DATA_WIDTH  instruction at FIFO head.
- `inst_pc`  out  DATA_WIDTH  PC of `inst`.
- `dec_ready`  in  1  decode accepts head this cycle (pop when `inst_valid`&`dec_ready`).
- `fault`  out  1  sticky illegal-fetch flag.
- `fault_pc`  out  DATA_WIDTH  offending address, held while `fault`=1.

## Operation
State:
- `fetch_pc`
- FIFO of {pc, word} entries: read/write pointers plus an occupancy count of 0..FIFO_DEPTH
- `fault`/`fault_pc`

Modes: RUN (fault=0) and HALT (fault=1); HALT exits only via `rst`.

Per edge, in RUN, priority order:
1. `rst`=1:
   - fetch_pc←RESET_PC.
   - FIFO emptied.
   - fault←0, fault_pc←0.
2. `redirect_valid`=1:
   - FIFO flushed; a simultaneous pop and push are discarded.
   - If target[1:0]≠0 or target is outside the window: fault←1, fault_pc←target, enter HALT.
   - Otherwise fetch_pc←target.
3. Otherwise, pop and push are evaluated independently:
   - Pop: when `inst_valid`&`dec_ready`.
   - Push: {fetch_pc, imem_rd}, allowed when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs this cycle.
   - On push, fetch_pc←fetch_pc+4, computed modulo 2^DATA_WIDTH.
   - If the incremented PC leaves the window, raise no fault yet. The fault is raised on the next cycle, when that PC would be pushed: no push, fault←1, fault_pc←fetch_pc, HALT.

In HALT:
- No pushes.
- Redirects are ignored.
- The FIFO still drains to decode.

Range check uses unsigned compare: RESET_PC ≤ pc ≤ RESET_PC+4*(IMEM_WORDS-1).

`imem_addr` is combinational from fetch_pc; it is never driven to a misaligned value.

Handshake:
- While `inst_valid`=1 and `dec_ready`=0, `inst`/`inst_pc` stay stable (a redirect excepted).
- `inst_valid` never drops without a pop, a redirect or `rst`.

## Timing
Reset values:
- `inst_valid`=0
- `inst`, `inst_pc`: don't-care while invalid; the RTL drives 0 from empty storage.
- `fault`=0, `fault_pc`=0
- `imem_addr`=RESET_PC

Latency and throughput:
- First cycle after `rst` deasserts: `imem_addr`=RESET_PC and the word is pushed at that edge. The next cycle shows `inst_valid`=1, `inst_pc`=RESET_PC.
- Fetch-to-present latency is 1 cycle.
- Throughput is 1 instruction/cycle with `dec_ready` held high. The FIFO never exceeds 1 entry in steady state.
- When `dec_ready` is low, the FIFO fills to FIFO_DEPTH and fetch stalls; `imem_addr` holds.
- When `dec_ready` rises with a full FIFO, the pop and the push occur at the same edge. There is no bubble.

Redirect penalty:
- Redirect at edge N: cycle N+1 has `inst_valid`=0 and `imem_addr`=target.
- Cycle N+2 has `inst_valid`=1, `inst_pc`=target.
- Back-to-back redirects: the last one wins.
- `rst` asserted mid-stream: FIFO contents are discarded in one cycle, regardless of `dec_ready`.

## Test plan
- Reset then `dec_ready`=1, ROM word k = 0x1000_0000+k → `inst_pc` sequence 0x400000, 0x400004, 0x400008…, one per cycle, `inst` matching, first valid 1 cycle after reset release.
- `dec_ready` low 5 cycles after first valid → FIFO holds 2 entries, `imem_addr` frozen at 0x400008, `inst` stable at 0x400000. Release → 0x400000, 0x400004, 0x400008 with no bubble.
- Redirect to 0x400040 while the FIFO is full and `dec_ready`=1 → FIFO flushed, one invalid cycle, then `inst_pc`=0x400040 followed by 0x400044.
- Redirect to 0x400042 → `fault`=1 and `fault_pc`=0x400042 next cycle. No further pushes; later redirects are ignored; buffered entries do not reappear (they were flushed).
- Redirect to 0x400FFC (last word) → that instruction is delivered. The next cycle raises `fault` with `fault_pc`=0x401000 and `inst_valid` drops.
- Assert `rst` while `inst_valid`=1, `dec_ready`=0, `fault`=1 → the next cycle shows `inst_valid`=0, `fault`=0, `imem_addr`=0x400000.
